// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb
//  Description : Round-robin write-port arbiter in front of fifo_asyn. It shares
//                one FIFO write port among N_REQ requesters, granting whole
//                bursts of BURST_LEN beats and stalling while the FIFO is full.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int FIFO_DWTH = 4,
    parameter int N_REQ     = 4,
    parameter int BURST_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*FIFO_DWTH-1:0]   req_din,
    input  logic                         full,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             req_ack,
    output logic                         wren,
    output logic [FIFO_DWTH-1:0]         din,
    output logic                         busy,
    output logic                         burst_done
);

    localparam int c_CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST_LEN - 1);
    // Reset value of the last pointer: makes requester 0 the first candidate.
    localparam logic [c_IDX_W-1:0] c_LAST_TOP = c_IDX_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_REQ-1:0]      r_gnt;
    logic [N_REQ-1:0]      w_gnt_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_IDX_W-1:0]    r_last;
    logic [c_IDX_W-1:0]    w_last_nxt;

    logic                  w_found;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_IDX_W-1:0]    w_sel;
    logic [N_REQ-1:0]      w_sel_oh;
    logic                  w_in_burst;
    logic                  w_gnt_req;
    logic                  w_beat;
    logic                  w_done;
    logic                  w_abort;
    logic [FIFO_DWTH-1:0]  w_din;

    // Round-robin pick: walk last+1, last+2, ... (wrapping) and take the first requester seen
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_idx   = r_last;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (w_idx == c_LAST_TOP) ? '0 : (w_idx + c_IDX_W'(1));
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // One-hot form of the selected requester, loaded into the grant register
    always_comb begin
        w_sel_oh        = '0;
        w_sel_oh[w_sel] = 1'b1;
    end

    // Beat qualification: the granted requester still asks and the FIFO has room.
    // The grant register is zero outside a burst, so these all collapse to 0 in IDLE.
    assign w_in_burst = (r_state == ST_BURST);
    assign w_gnt_req  = |(r_gnt & req);
    assign w_beat     = w_in_burst & w_gnt_req & ~full;
    assign w_done     = w_beat & (r_cnt == c_CNT_LAST);
    assign w_abort    = w_in_burst & ~w_gnt_req;

    // Write-data mux driven straight from the one-hot grant; yields 0 when nothing is granted
    always_comb begin
        w_din = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_din = w_din | req_din[i*FIFO_DWTH +: FIFO_DWTH];
            end
        end
    end

    // FSM state and burst bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_last  <= c_LAST_TOP;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic: grant in IDLE, count beats in BURST, leave on completion or abort
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BURST;
                    w_gnt_nxt   = w_sel_oh;
                    w_last_nxt  = w_sel;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BURST: begin
                // An aborted burst keeps last on the aborting requester so it
                // drops to the back of the rotation like a completed one.
                if (w_done || w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign gnt        = r_gnt;
    assign req_ack    = r_gnt & {N_REQ{w_beat}};
    assign wren       = w_beat;
    assign din        = w_din;
    assign busy       = w_in_burst;
    assign burst_done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arb
//  Description : Self-checking bench for fifo_wr_arb: vector table, directed
//                multi-cycle sequences and randomized traffic against a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arb;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int BL = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_din;
    logic           full;
    logic [N-1:0]   gnt;
    logic [N-1:0]   req_ack;
    logic           wren;
    logic [W-1:0]   din;
    logic           busy;
    logic           burst_done;

    fifo_wr_arb #(
        .FIFO_DWTH (W),
        .N_REQ     (N),
        .BURST_LEN (BL)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_din    (req_din),
        .full       (full),
        .gnt        (gnt),
        .req_ack    (req_ack),
        .wren       (wren),
        .din        (din),
        .busy       (busy),
        .burst_done (burst_done)
    );

    // Free-running write clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner of the current burst (-1 = none), beats so far,
    // last granted requester, and each requester's next data sequence number.
    int m_owner;
    int m_beats;
    int m_last;
    int dcnt [N];

    // Values observed from the DUT in the most recent step
    logic [N-1:0] ob_gnt;
    logic [N-1:0] ob_ack;
    logic         ob_wren;
    logic         ob_busy;
    logic         ob_done;
    logic [W-1:0] ob_din;

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] gnt;
        logic         wren;
        logic         done;
        logic         busy;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
        for (int i = 0; i < N; i++) dcnt[i] = 0;
    endtask

    // Requester i presents word (i<<2 | n), n being its consumed-word count mod 4
    function automatic logic [W-1:0] word_of(input int i);
        return W'((i << 2) | (dcnt[i] & 3));
    endfunction

    function automatic logic [N*W-1:0] pack_din();
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = word_of(i);
        return r;
    endfunction

    // One clock cycle: drive inputs, check DUT against the model mid-cycle, advance the model
    task automatic step(input logic [N-1:0] rq, input logic fl, input string tag);
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_ack;
        logic         e_wren;
        logic         e_busy;
        logic         e_done;
        logic [W-1:0] e_din;
        logic         found;
        int           cand;
        req     = rq;
        full    = fl;
        req_din = pack_din();
        e_gnt = '0; e_ack = '0; e_wren = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_din = '0;
        if (m_owner >= 0) begin
            e_gnt  = N'(1) << m_owner;
            e_busy = 1'b1;
            e_din  = word_of(m_owner);
            e_wren = rq[m_owner] && !fl;
            e_ack  = e_wren ? e_gnt : '0;
            e_done = e_wren && (m_beats == BL - 1);
        end
        @(negedge clk);
        ob_gnt  = gnt;
        ob_ack  = req_ack;
        ob_wren = wren;
        ob_busy = busy;
        ob_done = burst_done;
        ob_din  = din;
        chk({tag, "_gnt"},    32'(ob_gnt),  32'(e_gnt));
        chk({tag, "_ack"},    32'(ob_ack),  32'(e_ack));
        chk({tag, "_wren"},   32'(ob_wren), 32'(e_wren));
        chk({tag, "_busy"},   32'(ob_busy), 32'(e_busy));
        chk({tag, "_done"},   32'(ob_done), 32'(e_done));
        chk({tag, "_din"},    32'(ob_din),  32'(e_din));
        chk({tag, "_onehot"}, 32'($onehot0(ob_gnt)), 32'(1));
        @(posedge clk);
        #1;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                cand = (m_last + k) % N;
                if (!found && rq[cand]) begin
                    found   = 1'b1;
                    m_owner = cand;
                    m_last  = cand;
                    m_beats = 0;
                end
            end
        end else if (e_done || !rq[m_owner]) begin
            m_owner = -1;
        end else if (e_wren) begin
            m_beats++;
        end
        for (int i = 0; i < N; i++) if (e_ack[i]) dcnt[i]++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        full = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [N-1:0] rq, input logic fl, input logic [N-1:0] g,
                       input logic w, input logic d, input logic b);
        vec_t v;
        v.req = rq; v.full = fl; v.gnt = g; v.wren = w; v.done = d; v.busy = b;
        tbl.push_back(v);
    endtask

    // Bound on total run time
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_order [5];
        logic [N-1:0] order [$];
        int           lens [$];
        int           gaps [$];
        logic [N-1:0] prev;
        int           wr;
        int           gap;
        bit           started;
        int           nwr;
        int           ndone;
        logic [N-1:0] rq;

        // ---------------- vector table: single requester bursts and stall ----
        add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int b = 1; b <= BL; b++) add(4'b0001, 1'b0, 4'b0001, 1'b1, (b == BL), 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int b = 1; b <= 3; b++) add(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 3; s++)  add(4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
        for (int b = 4; b <= BL; b++) add(4'b0001, 1'b0, 4'b0001, 1'b1, (b == BL), 1'b1);
        add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // ---------------- reset state -----------------------------------------
        rst     = 1'b1;
        req     = 4'b1111;
        full    = 1'b0;
        req_din = 16'hFFFF;
        #3;
        chk("rst_gnt",  32'(gnt),        32'(0));
        chk("rst_wren", 32'(wren),       32'(0));
        chk("rst_busy", 32'(busy),       32'(0));
        chk("rst_done", 32'(burst_done), 32'(0));
        chk("rst_ack",  32'(req_ack),    32'(0));
        chk("rst_din",  32'(din),        32'(0));
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].full, "tbl");
            chk($sformatf("tbl%0d_gnt", i),  32'(ob_gnt),  32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_wren", i), 32'(ob_wren), 32'(tbl[i].wren));
            chk($sformatf("tbl%0d_done", i), 32'(ob_done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_busy", i), 32'(ob_busy), 32'(tbl[i].busy));
        end

        // ---------------- all requesters held: rotation order -----------------
        do_reset();
        prev = '0; wr = 0; gap = 0; started = 1'b0;
        for (int c = 0; c < 39; c++) begin
            step(4'b1111, 1'b0, "rr");
            if (ob_gnt != 0) begin
                if (prev == 0) begin
                    order.push_back(ob_gnt);
                    if (started) gaps.push_back(gap);
                    started = 1'b1;
                    gap     = 0;
                end
                if (ob_wren) wr++;
            end else begin
                if (prev != 0) begin
                    lens.push_back(wr);
                    wr = 0;
                end
                if (started) gap++;
            end
            prev = ob_gnt;
        end
        chk("rr_ngrants", 32'(order.size()), 32'(5));
        for (int k = 0; k < 5; k++)
            if (k < order.size()) chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        chk("rr_nbursts", 32'(lens.size()), 32'(4));
        for (int k = 0; k < lens.size(); k++) chk($sformatf("rr_len%0d", k), 32'(lens[k]), 32'(BL));
        chk("rr_ngaps", 32'(gaps.size()), 32'(4));
        for (int k = 0; k < gaps.size(); k++) chk($sformatf("rr_gap%0d", k), 32'(gaps[k]), 32'(1));

        // ---------------- abort after 3 beats, other requester pending --------
        do_reset();
        nwr = 0; ndone = 0;
        step(4'b0100, 1'b0, "ab");
        for (int b = 0; b < 3; b++) begin
            step(4'b1100, 1'b0, "ab");
            nwr += int'(ob_wren);
            ndone += int'(ob_done);
        end
        step(4'b1000, 1'b0, "ab");
        chk("ab_abort_gnt",  32'(ob_gnt),  32'(4'b0100));
        chk("ab_abort_wren", 32'(ob_wren), 32'(0));
        nwr += int'(ob_wren);
        ndone += int'(ob_done);
        chk("ab_nwren", 32'(nwr),   32'(3));
        chk("ab_ndone", 32'(ndone), 32'(0));
        step(4'b1000, 1'b0, "ab");
        chk("ab_idle_gnt", 32'(ob_gnt), 32'(0));
        step(4'b1000, 1'b0, "ab");
        chk("ab_next_gnt", 32'(ob_gnt), 32'(4'b1000));

        // ---------------- asynchronous reset in the middle of a burst ---------
        do_reset();
        step(4'b0001, 1'b0, "ar");
        for (int b = 0; b < 5; b++) step(4'b0001, 1'b0, "ar");
        chk("ar_pre_busy", 32'(busy), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt",  32'(gnt),        32'(0));
        chk("ar_wren", 32'(wren),       32'(0));
        chk("ar_busy", 32'(busy),       32'(0));
        chk("ar_done", 32'(burst_done), 32'(0));
        req = '0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(4'b0011, 1'b0, "ar");
        chk("ar_idle_gnt", 32'(ob_gnt), 32'(0));
        step(4'b0011, 1'b0, "ar");
        chk("ar_first_gnt", 32'(ob_gnt), 32'(4'b0001));

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        rq = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) rq[i] = ~rq[i];
            step(rq, ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
